// File: rtl/drop_control.sv
// Drop controller for a COLS x ROWS disc board: per-column height counters plus a
// request FSM that validates a column and sequences the 16 pixel plots of one disc.
module drop_control #(
    parameter int COLS = 7,
    parameter int ROWS = 6
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic [2:0] location,
    output logic [2:0] column,
    output logic [2:0] decoded_height,
    output logic [3:0] pixel_count,
    output logic       player,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       reject,
    output logic       board_full
);

    typedef enum logic [1:0] {IDLE, CHECK, DRAW, FINISH} state_t;

    state_t                  state_q, state_d;
    logic [COLS-1:0][2:0]    height_q, height_d;
    logic [2:0]              column_q, column_d;
    logic [2:0]              dheight_q, dheight_d;
    logic [3:0]              pix_q, pix_d;
    logic                    player_q, player_d;
    logic                    plot_q, plot_d;
    logic                    done_q, done_d;
    logic                    reject_q, reject_d;
    logic                    go_q, go_d;
    logic                    arm_q, arm_d;
    logic [2:0]              loc_h, col_h;
    logic                    go_rise, loc_bad, full;

    always_comb begin
        loc_h = '0;
        col_h = '0;
        full  = 1'b1;
        for (int i = 0; i < COLS; i++) begin
            if (location == 3'(i)) loc_h = height_q[i];
            if (column_q == 3'(i)) col_h = height_q[i];
            full = full & (height_q[i] == 3'(ROWS));
        end
    end

    // arm_q masks the first cycle after reset so a go already held high is not an edge
    assign go_rise = go & ~go_q & arm_q;
    assign loc_bad = (int'(location) >= COLS) || (loc_h == 3'(ROWS));

    always_comb begin
        state_d   = state_q;
        height_d  = height_q;
        column_d  = column_q;
        dheight_d = dheight_q;
        pix_d     = pix_q;
        player_d  = player_q;
        plot_d    = 1'b0;
        done_d    = 1'b0;
        reject_d  = 1'b0;
        go_d      = go;
        arm_d     = 1'b1;
        case (state_q)
            IDLE: if (go_rise) begin
                state_d  = CHECK;
                column_d = location;
                reject_d = loc_bad;
            end
            // reject_q already carries the verdict, so CHECK only steers
            CHECK: if (reject_q) begin
                state_d = IDLE;
            end else begin
                state_d   = DRAW;
                dheight_d = col_h;
                pix_d     = 4'd0;
                plot_d    = 1'b1;
            end
            DRAW: begin
                pix_d = pix_q + 4'd1;
                if (pix_q == 4'd15) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    plot_d = 1'b1;
                end
            end
            FINISH: begin
                state_d  = IDLE;
                player_d = ~player_q;
                for (int i = 0; i < COLS; i++)
                    if (column_q == 3'(i) && height_q[i] != 3'(ROWS))
                        height_d[i] = height_q[i] + 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            height_q  <= '0;
            column_q  <= '0;
            dheight_q <= '0;
            pix_q     <= '0;
            player_q  <= 1'b0;
            plot_q    <= 1'b0;
            done_q    <= 1'b0;
            reject_q  <= 1'b0;
            go_q      <= 1'b0;
            arm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            height_q  <= height_d;
            column_q  <= column_d;
            dheight_q <= dheight_d;
            pix_q     <= pix_d;
            player_q  <= player_d;
            plot_q    <= plot_d;
            done_q    <= done_d;
            reject_q  <= reject_d;
            go_q      <= go_d;
            arm_q     <= arm_d;
        end
    end

    assign column         = column_q;
    assign decoded_height = dheight_q;
    assign pixel_count    = pix_q;
    assign player         = player_q;
    assign plot           = plot_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign reject         = reject_q;
    assign board_full     = full;

endmodule

// File: tb/tb_drop_control.sv
// Scoreboard bench for drop_control: a board model predicts every plot/done/reject
// event, a negedge monitor records what the DUT emits, and each test compares the two.
module tb_drop_control;

    logic       clk, resetn, go;
    logic [2:0] location;
    logic [2:0] column, decoded_height;
    logic [3:0] pixel_count;
    logic       player, plot, busy, done, reject, board_full;

    drop_control #(.COLS(7), .ROWS(6)) dut (
        .clk(clk), .resetn(resetn), .go(go), .location(location),
        .column(column), .decoded_height(decoded_height), .pixel_count(pixel_count),
        .player(player), .plot(plot), .busy(busy), .done(done), .reject(reject),
        .board_full(board_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] col;
        logic [2:0] dh;
        logic       pl;
        logic [3:0] pix;
    } ev_t;

    localparam logic [1:0] K_PLOT = 2'd1, K_DONE = 2'd2, K_REJ = 2'd3;

    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t e;
    int  rd = 0;
    int  errors = 0;
    int  checks = 0;

    int   mh[8];
    logic [2:0] m_dh;
    logic       m_player;

    function automatic ev_t mk(logic [1:0] k, logic [2:0] c, logic [2:0] d, logic p, logic [3:0] x);
        ev_t r;
        r.kind = k; r.col = c; r.dh = d; r.pl = p; r.pix = x;
        return r;
    endfunction

    always @(negedge clk) begin
        if (resetn) begin
            if (plot)   obs_q.push_back(mk(K_PLOT, column, decoded_height, player, pixel_count));
            if (done)   obs_q.push_back(mk(K_DONE, column, decoded_height, player, 4'd0));
            if (reject) obs_q.push_back(mk(K_REJ,  column, decoded_height, player, 4'd0));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mh[i] = 0;
        m_dh = 3'd0;
        m_player = 1'b0;
    endtask

    task automatic expect_req(input logic [2:0] loc);
        if (loc >= 3'd7 || mh[loc] == 6) begin
            exp_q.push_back(mk(K_REJ, loc, m_dh, m_player, 4'd0));
        end else begin
            for (int p = 0; p < 16; p++)
                exp_q.push_back(mk(K_PLOT, loc, 3'(mh[loc]), m_player, 4'(p)));
            exp_q.push_back(mk(K_DONE, loc, 3'(mh[loc]), m_player, 4'd0));
            m_dh = 3'(mh[loc]);
            mh[loc]++;
            m_player = ~m_player;
        end
    endtask

    task automatic do_req(input logic [2:0] loc);
        @(negedge clk);
        location = loc;
        go = 1'b1;
        expect_req(loc);
        @(negedge clk);
        go = 1'b0;
        repeat (22) @(negedge clk);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        go = 1'b0;
        location = 3'd0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        model_reset();
        exp_q.delete();
        rd = obs_q.size();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        go = 1'b0;
        location = 3'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({column, decoded_height, pixel_count, player, plot, busy, done, reject, board_full} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0",
                     {column, decoded_height, pixel_count, player, plot, busy, done, reject, board_full});
        end
        resetn = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_drop();
        int lat;
        @(negedge clk);
        location = 3'd3;
        go = 1'b1;
        expect_req(3'd3);
        lat = 1;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 2) go = 1'b0;
            if (done) break;
        end
        checks++;
        if (lat !== 19) begin errors++; $display("FAIL single_latency: got %0d want 19", lat); end
        repeat (3) @(negedge clk);
        checks++;
        if (player !== m_player) begin errors++; $display("FAIL single_player: got %0d want %0d", player, m_player); end
        checks++;
        if (column !== 3'd3 || busy !== 1'b0) begin
            errors++; $display("FAIL single_hold: got col=%0d busy=%0d want col=3 busy=0", column, busy);
        end
        checks++;
        if (obs_q.size() - rd !== exp_q.size()) begin
            errors++; $display("FAIL single_count: got %0d events want %0d", obs_q.size() - rd, exp_q.size());
        end
        while (exp_q.size() > 0 && rd < obs_q.size()) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q[rd] !== e) begin errors++; $display("FAIL single_ev: got %h want %h", obs_q[rd], e); end
            rd++;
        end
        exp_q.delete(); rd = obs_q.size();
    endtask

    task automatic test_column_fill();
        for (int k = 0; k < 7; k++) do_req(3'd0);
        checks++;
        if (board_full !== 1'b0) begin errors++; $display("FAIL fill_board_full: got %0d want 0", board_full); end
        checks++;
        if (obs_q.size() - rd !== exp_q.size()) begin
            errors++; $display("FAIL fill_count: got %0d events want %0d", obs_q.size() - rd, exp_q.size());
        end
        while (exp_q.size() > 0 && rd < obs_q.size()) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q[rd] !== e) begin errors++; $display("FAIL fill_ev: got %h want %h", obs_q[rd], e); end
            rd++;
        end
        exp_q.delete(); rd = obs_q.size();
    endtask

    task automatic test_illegal_column();
        do_req(3'd7);
        do_req(3'd6);
        checks++;
        if (obs_q.size() - rd !== exp_q.size()) begin
            errors++; $display("FAIL illegal_count: got %0d events want %0d", obs_q.size() - rd, exp_q.size());
        end
        while (exp_q.size() > 0 && rd < obs_q.size()) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q[rd] !== e) begin errors++; $display("FAIL illegal_ev: got %h want %h", obs_q[rd], e); end
            rd++;
        end
        exp_q.delete(); rd = obs_q.size();
    endtask

    task automatic test_busy_ignore();
        int n;
        @(negedge clk);
        location = 3'd4;
        go = 1'b1;
        expect_req(3'd4);
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (n < 30 && !(plot && pixel_count == 4'd5)) begin @(negedge clk); n++; end
        checks++;
        if (n >= 30) begin errors++; $display("FAIL busy_wait: got timeout want pixel_count=5"); end
        location = 3'd2;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (22) @(negedge clk);
        do_req(3'd2);
        checks++;
        if (obs_q.size() - rd !== exp_q.size()) begin
            errors++; $display("FAIL busy_count: got %0d events want %0d", obs_q.size() - rd, exp_q.size());
        end
        while (exp_q.size() > 0 && rd < obs_q.size()) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q[rd] !== e) begin errors++; $display("FAIL busy_ev: got %h want %h", obs_q[rd], e); end
            rd++;
        end
        exp_q.delete(); rd = obs_q.size();
    endtask

    task automatic test_mid_draw_reset();
        int n;
        @(negedge clk);
        location = 3'd5;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (n < 30 && !(plot && pixel_count == 4'd9)) begin @(negedge clk); n++; end
        checks++;
        if (n >= 30) begin errors++; $display("FAIL rst_wait: got timeout want pixel_count=9"); end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if ({column, decoded_height, pixel_count, player, plot, busy, done, reject, board_full} !== 17'd0) begin
            errors++;
            $display("FAIL rst_async: got %h want 0",
                     {column, decoded_height, pixel_count, player, plot, busy, done, reject, board_full});
        end
        go = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        exp_q.delete();
        rd = obs_q.size();
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || obs_q.size() !== rd) begin
            errors++; $display("FAIL rst_go_held: got busy=%0d events=%0d want busy=0 events=0", busy, obs_q.size() - rd);
        end
        go = 1'b0;
        do_req(3'd5);
        checks++;
        if (obs_q.size() - rd !== exp_q.size()) begin
            errors++; $display("FAIL rst_count: got %0d events want %0d", obs_q.size() - rd, exp_q.size());
        end
        while (exp_q.size() > 0 && rd < obs_q.size()) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q[rd] !== e) begin errors++; $display("FAIL rst_ev: got %h want %h", obs_q[rd], e); end
            rd++;
        end
        exp_q.delete(); rd = obs_q.size();
    endtask

    task automatic test_full_board();
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                if (c == 6 && r == 5) begin
                    checks++;
                    if (board_full !== 1'b0) begin errors++; $display("FAIL full_early: got %0d want 0", board_full); end
                end
                do_req(3'(c));
            end
        end
        checks++;
        if (board_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %0d want 1", board_full); end
        checks++;
        if (player !== m_player) begin errors++; $display("FAIL full_player: got %0d want %0d", player, m_player); end
        do_req(3'd1);
        checks++;
        if (obs_q.size() - rd !== exp_q.size()) begin
            errors++; $display("FAIL full_count: got %0d events want %0d", obs_q.size() - rd, exp_q.size());
        end
        while (exp_q.size() > 0 && rd < obs_q.size()) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q[rd] !== e) begin errors++; $display("FAIL full_ev: got %h want %h", obs_q[rd], e); end
            rd++;
        end
        exp_q.delete(); rd = obs_q.size();
    endtask

    initial begin
        resetn = 1'b0;
        go = 1'b0;
        location = 3'd0;
        model_reset();
        test_reset();
        test_single_drop();
        test_column_fill();
        test_illegal_column();
        test_busy_ignore();
        test_mid_draw_reset();
        test_full_board();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
